xor_rotate_cipher_buffered: RTL and testbench
=============================================

Name: xor_rotate_cipher_buffered

Overview:
Parametrised successor to the single-word XOR/rotated-key encrypter. It sits between the parallelizer and the collector. Each accepted word is XORed with a programmable key that is rotated left by a per-word amount. Results are queued in an internal output FIFO so the parallelizer can keep streaming while the collector stalls. It adds generic width, modulo rotation, an auto-incrementing rotation mode and back-pressure via FIFO occupancy.

Parameters:
DATA_WIDTH, 32, width of data words and key (any value ≥2)
ROT_WIDTH, 6, width of key_rotation_p; rotation values are reduced modulo DATA_WIDTH
FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
data_in_p  in  DATA_WIDTH  key (when prog_p) or plaintext word
key_rotation_p  in  ROT_WIDTH  base rotate-left amount for current word
prog_p  in  1  key-load strobe
auto_rot_en  in  1  1: add running word count to rotation
data_ready_in_p  in  1  parallelizer word valid
ready_p  out  1  block can accept a word
data_out_c  out  DATA_WIDTH  FIFO head (ciphertext)
data_ready_out_c  out  1  FIFO non-empty
capture_c  in  1  collector pops head
key_loaded  out  1  key has been programmed since reset
fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Reset (async, any time incl. mid-transfer):
  - Outputs: ready_p=0, data_ready_out_c=0, data_out_c=0, key_loaded=0, fifo_count=0.
  - Internal: key=0, word_cnt=0, FIFO pointers=0.
- States:
  - UNKEYED: after reset; data ignored. Goes to KEYED on prog_p.
  - KEYED: streaming.
- Key load: at a posedge with prog_p=1, key<=data_in_p, word_cnt<=0, key_loaded<=1.
  - prog_p has priority: data_ready_in_p is ignored that cycle.
  - Reprogramming in KEYED leaves FIFO contents intact; words already queued keep the old key.
- Accept condition: posedge with data_ready_in_p && ready_p && !prog_p.
- ready_p is registered:
  - ready_p = key_loaded && (occupancy after this edge < FIFO_DEPTH).
  - It deasserts on the same edge that fills the FIFO.
- Effective rotation:
  - r = (key_rotation_p + (auto_rot_en ? word_cnt : 0)) mod DATA_WIDTH.
  - Compute the sum at ROT_WIDTH+1 bits before the modulo.
  - r=0 yields the unrotated key; no shift-by-width artefact.
- Ciphertext = data_in_p XOR rotl(key, r). It is written to the FIFO tail on the accept edge.
- word_cnt increments on every accept and wraps at 2^ROT_WIDTH. It increments regardless of auto_rot_en.
- Latency: a word accepted at edge N appears at data_out_c after edge N if the FIFO was empty.
  - Otherwise it appears after all earlier entries are popped.
- Output side:
  - data_ready_out_c = (fifo_count != 0).
  - data_out_c = head entry; holds its last value when empty.
- Pop condition: posedge with capture_c && data_ready_out_c.
  - capture_c held high pops one word per cycle.
  - capture_c while empty is ignored.
- Simultaneous push and pop: fifo_count is unchanged and ordering is preserved.
  - When full, ready_p=0, so no push occurs; a pop that cycle raises ready_p at the next edge.
- Pointers wrap modulo FIFO_DEPTH. No overflow or underflow is possible by construction; assert this in simulation.

Test Plan:
All scenarios use DATA_WIDTH=8, ROT_WIDTH=4, FIFO_DEPTH=4.
- Basic encrypt: prog_p with 0x81; push 0xF0 with rot=1, auto off -> data_out_c=0xF3 one edge after accept, data_ready_out_c=1; capture -> fifo_count=0.
- Rotation bounds: key 0x81; push 0x0F rot=0 -> 0x8E; push 0x00 rot=9 -> 0x03 (9 mod 8 = 1); push 0x00 rot=8 -> 0x81.
- Auto mode: key 0x81, auto_rot_en=1, rot=0; push 0x00 three times -> 0x81, 0x03, 0x06; reprogram key 0x81 -> next 0x00 word gives 0x81.
- Back-pressure: capture_c=0, push 5 words back-to-back -> ready_p low after 4th accept, fifo_count=4, 5th word not accepted.
  - Then one capture -> ready_p high next edge, order preserved.
- Simultaneous push/pop and priority:
  - With fifo_count=2, push and capture in the same cycle -> count stays 2.
  - prog_p and data_ready_in_p together -> key loaded, no word queued.
- Reset mid-stream: 3 words queued, assert reset between edges -> outputs 0 immediately (asynchronously), key_loaded=0; data pushed before a new prog_p is ignored.

Source files
------------

// File: rtl/xor_rotate_cipher_buffered.sv
// xor_rotate_cipher_buffered
//   Encrypts each accepted word as data XOR rotl(key, r) and queues the
//   ciphertext in a small output FIFO so the upstream producer can keep
//   streaming while the downstream consumer stalls.
//
// Handshake (both sides): a transfer happens at a posedge where the
//   producer's valid and the consumer's ready are both high. Upstream:
//   data_ready_in_p is valid, ready_p is ready (prog_p blocks the transfer).
//   Downstream: data_ready_out_c is valid, capture_c is ready/pop.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   data_in_p         key (when prog_p) or plaintext word
//   key_rotation_p    base rotate-left amount for the current word
//   prog_p            key-load strobe, has priority over data
//   auto_rot_en       add running word count to the rotation
//   data_ready_in_p   upstream word valid
//   ready_p           block can accept a word (registered)
//   data_out_c        FIFO head (ciphertext), holds last value when empty
//   data_ready_out_c  FIFO non-empty
//   capture_c         downstream pops the head
//   key_loaded        key programmed since reset; doubles as FSM state view
//   fifo_count        current FIFO occupancy
module xor_rotate_cipher_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int ROT_WIDTH  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             data_in_p,
  input  logic [ROT_WIDTH-1:0]              key_rotation_p,
  input  logic                              prog_p,
  input  logic                              auto_rot_en,
  input  logic                              data_ready_in_p,
  output logic                              ready_p,
  output logic [DATA_WIDTH-1:0]             data_out_c,
  output logic                              data_ready_out_c,
  input  logic                              capture_c,
  output logic                              key_loaded,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef enum logic {UNKEYED = 1'b0, KEYED = 1'b1} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   key;
  logic [ROT_WIDTH-1:0]    word_cnt;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count_next;
  logic                    ready_next;
  logic [DATA_WIDTH-1:0]   head_next;
  logic                    push;
  logic                    pop;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= UNKEYED;
    else       state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    if (prog_p) state_next = KEYED;
  end

  // ---------------- FSM: outputs ----------------
  // key_loaded is the externally visible copy of the FSM state.
  always_comb begin
    key_loaded = (state == KEYED);
  end

  // ---------------- datapath ----------------
  assign push             = data_ready_in_p && ready_p && !prog_p;
  assign data_ready_out_c = (fifo_count != '0);
  assign pop              = capture_c && data_ready_out_c;

  // Sum at ROT_WIDTH+1 bits so base + word count cannot overflow before
  // the modulo reduction.
  logic [ROT_WIDTH:0]        rot_sum;
  logic [31:0]               rot_amt;
  logic [2*DATA_WIDTH-1:0]   key_dbl;
  logic [DATA_WIDTH-1:0]     cipher;

  always_comb begin
    rot_sum = {1'b0, key_rotation_p} + (auto_rot_en ? {1'b0, word_cnt} : '0);
    rot_amt = 32'(rot_sum) % 32'(DATA_WIDTH);
    // Rotating via a doubled word: shift by 0 leaves the key in the upper
    // half, so r=0 needs no special case.
    key_dbl = {key, key} << rot_amt;
    cipher  = data_in_p ^ key_dbl[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + CW'(1);
      2'b01:   count_next = fifo_count - CW'(1);
      default: count_next = fifo_count;
    endcase
    ready_next = (state_next == KEYED) && (count_next < CW'(FIFO_DEPTH));
  end

  // data_out_c is a register so it can hold its last value after the FIFO
  // drains. The word becoming head is either the next stored entry or, when
  // the FIFO is (or becomes) otherwise empty, the word being pushed now.
  always_comb begin
    head_next = data_out_c;
    if (pop) begin
      if (fifo_count > CW'(1)) head_next = mem[rd_ptr + PW'(1)];
      else if (push)           head_next = cipher;
    end else if (push && (fifo_count == '0)) begin
      head_next = cipher;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key        <= '0;
      word_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ready_p    <= 1'b0;
      data_out_c <= '0;
    end else begin
      if (prog_p) begin
        key      <= data_in_p;
        word_cnt <= '0;
      end else if (push) begin
        word_cnt <= word_cnt + ROT_WIDTH'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_next;
      ready_p    <= ready_next;
      data_out_c <= head_next;
    end
  end

  // Storage array carries no reset; entries are only read after a write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cipher;
  end

  no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> (fifo_count < CW'(FIFO_DEPTH)));
  no_underflow: assert property (@(posedge clk) disable iff (reset)
    pop |-> (fifo_count != '0));
  count_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_xor_rotate_cipher_buffered.sv
// Testbench for xor_rotate_cipher_buffered with DATA_WIDTH=8, ROT_WIDTH=4,
// FIFO_DEPTH=4. Directed, hand-computed vectors.
module tb_xor_rotate_cipher_buffered;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in_p;
  logic [3:0] key_rotation_p;
  logic       prog_p;
  logic       auto_rot_en;
  logic       data_ready_in_p;
  logic       ready_p;
  logic [7:0] data_out_c;
  logic       data_ready_out_c;
  logic       capture_c;
  logic       key_loaded;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] key;
    logic [7:0] data;
    logic [3:0] rot;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[8];

  xor_rotate_cipher_buffered #(
    .DATA_WIDTH(8), .ROT_WIDTH(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .data_in_p(data_in_p),
    .key_rotation_p(key_rotation_p), .prog_p(prog_p),
    .auto_rot_en(auto_rot_en), .data_ready_in_p(data_ready_in_p),
    .ready_p(ready_p), .data_out_c(data_out_c),
    .data_ready_out_c(data_ready_out_c), .capture_c(capture_c),
    .key_loaded(key_loaded), .fifo_count(fifo_count)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic prog_key(input logic [7:0] k);
    prog_p    = 1'b1;
    data_in_p = k;
    tick();
    prog_p    = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d, input logic [3:0] r);
    data_in_p       = d;
    key_rotation_p  = r;
    data_ready_in_p = 1'b1;
    tick();
    data_ready_in_p = 1'b0;
  endtask

  // ---------------- scoreboard drain ----------------
  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      check({name, "_valid"}, data_ready_out_c, 1);
      check({name, "_data"}, data_out_c, exp_q.pop_front());
      capture_c = 1'b1;
      tick();
      capture_c = 1'b0;
      guard++;
    end
    check({name, "_empty"}, fifo_count, 0);
    check({name, "_ready_out"}, data_ready_out_c, 0);
  endtask

  initial begin
    // key 0x81: rotl1=0x03, rotl2=0x06; 0xA5 rotl7=0xD2; 0x12 rotl3=0x90
    vecs[0] = '{8'h81, 8'hF0, 4'd1,  8'hF3};
    vecs[1] = '{8'h81, 8'h0F, 4'd0,  8'h8E};
    vecs[2] = '{8'h81, 8'h00, 4'd9,  8'h03};
    vecs[3] = '{8'h81, 8'h00, 4'd8,  8'h81};
    vecs[4] = '{8'h12, 8'h00, 4'd3,  8'h90};
    vecs[5] = '{8'hA5, 8'hFF, 4'd15, 8'h2D};
    vecs[6] = '{8'h01, 8'h00, 4'd7,  8'h80};
    vecs[7] = '{8'hF0, 8'h0F, 4'd4,  8'h00};

    reset = 1'b1; data_in_p = '0; key_rotation_p = '0; prog_p = 1'b0;
    auto_rot_en = 1'b0; data_ready_in_p = 1'b0; capture_c = 1'b0;
    #3;
    check("rst_ready", ready_p, 0);
    check("rst_valid", data_ready_out_c, 0);
    check("rst_data", data_out_c, 0);
    check("rst_key_loaded", key_loaded, 0);
    check("rst_count", fifo_count, 0);
    tick();
    reset = 1'b0;
    tick();

    // unkeyed: data ignored
    push_word(8'h55, 4'd0);
    check("unkeyed_count", fifo_count, 0);
    check("unkeyed_ready", ready_p, 0);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 8; i++) begin
      prog_key(vecs[i].key);
      check($sformatf("v%0d_key_loaded", i), key_loaded, 1);
      check($sformatf("v%0d_ready", i), ready_p, 1);
      push_word(vecs[i].data, vecs[i].rot);
      check($sformatf("v%0d_valid", i), data_ready_out_c, 1);
      check($sformatf("v%0d_data", i), data_out_c, vecs[i].exp);
      check($sformatf("v%0d_count1", i), fifo_count, 1);
      capture_c = 1'b1;
      tick();
      capture_c = 1'b0;
      check($sformatf("v%0d_count0", i), fifo_count, 0);
      check($sformatf("v%0d_hold", i), data_out_c, vecs[i].exp);
    end

    // capture while empty is ignored
    capture_c = 1'b1;
    tick();
    capture_c = 1'b0;
    check("empty_cap_count", fifo_count, 0);

    // ---------------- auto rotation ----------------
    auto_rot_en = 1'b1;
    prog_key(8'h81);
    data_in_p = 8'h00; key_rotation_p = 4'd0; data_ready_in_p = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    data_ready_in_p = 1'b0;
    exp_q.push_back(8'h81); exp_q.push_back(8'h03); exp_q.push_back(8'h06);
    check("auto_count", fifo_count, 3);
    drain("auto");
    prog_key(8'h81);
    push_word(8'h00, 4'd0);
    exp_q.push_back(8'h81);
    drain("auto_reprog");
    auto_rot_en = 1'b0;

    // ---------------- back-pressure ----------------
    prog_key(8'h81);
    key_rotation_p = 4'd1; data_ready_in_p = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in_p = 8'((i + 1) * 16);
      tick();
      if (i == 3) begin
        check("bp_ready_full", ready_p, 0);
        check("bp_count_full", fifo_count, 4);
      end
    end
    data_ready_in_p = 1'b0;
    check("bp_count_after5", fifo_count, 4);
    exp_q.push_back(8'h13); exp_q.push_back(8'h23);
    exp_q.push_back(8'h33); exp_q.push_back(8'h43);
    check("bp_head", data_out_c, exp_q.pop_front());
    capture_c = 1'b1;
    tick();
    capture_c = 1'b0;
    check("bp_ready_back", ready_p, 1);
    check("bp_count3", fifo_count, 3);
    drain("bp");

    // ---------------- simultaneous push/pop ----------------
    push_word(8'hA0, 4'd0);
    push_word(8'hB0, 4'd0);
    check("sim_count2", fifo_count, 2);
    check("sim_head_a", data_out_c, 8'h21);
    data_in_p = 8'hC0; data_ready_in_p = 1'b1; capture_c = 1'b1;
    tick();
    data_ready_in_p = 1'b0; capture_c = 1'b0;
    check("sim_count_same", fifo_count, 2);
    exp_q.push_back(8'h31); exp_q.push_back(8'h41);
    drain("sim");

    // ---------------- prog priority ----------------
    prog_p = 1'b1; data_ready_in_p = 1'b1; data_in_p = 8'h3C;
    tick();
    prog_p = 1'b0; data_ready_in_p = 1'b0;
    check("prio_count", fifo_count, 0);
    check("prio_valid", data_ready_out_c, 0);
    push_word(8'h00, 4'd0);
    exp_q.push_back(8'h3C);
    drain("prio");

    // ---------------- reset mid-stream ----------------
    prog_key(8'h81);
    push_word(8'h01, 4'd0);
    push_word(8'h02, 4'd0);
    push_word(8'h03, 4'd0);
    check("mid_count3", fifo_count, 3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ready", ready_p, 0);
    check("mid_rst_valid", data_ready_out_c, 0);
    check("mid_rst_data", data_out_c, 0);
    check("mid_rst_key", key_loaded, 0);
    check("mid_rst_count", fifo_count, 0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    push_word(8'h77, 4'd0);
    check("mid_ignored_count", fifo_count, 0);
    check("mid_ignored_key", key_loaded, 0);
    prog_key(8'h81);
    push_word(8'h0F, 4'd1);
    exp_q.push_back(8'h0C);
    drain("mid_after");

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
